stage_ex_md: RTL and testbench

Parametrised next-generation execute stage of the MIPS-like pipeline. It contains the existing alu instance and the branch resolution logic, and adds a multi-cycle multiply/divide unit with architectural HI/LO registers. It sits between decode and memory. Alongside the EX/MEM pipeline register it provides a stall request to the hazard logic and an explicit valid/flush path.

---
 rtl/stage_ex_md.sv | 233 +++++++++++++++++++++++
 tb/tb_stage_ex_md.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ex_md.sv
// Execute stage: alu, branch resolution, multi-cycle multiply/divide with HI/LO,
// and the EX/MEM pipeline register with stall/flush handling.
module stage_ex_md #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OPT_W  = 4,
    parameter int MEM_OPT_W  = 3,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [ALU_OPT_W-1:0]  alu_opt,
    input  logic                  alu_src_imm,
    input  logic [XLEN-1:0]       imm,
    input  logic [XLEN-1:0]       reg1_data,
    input  logic [XLEN-1:0]       reg2_data,
    input  logic [1:0]            branch_opt,
    input  logic [XLEN-1:0]       branch_dest_in,
    input  logic [3:0]            md_op,
    input  logic [REG_ADDR_W-1:0] wb_reg_addr_in,
    input  logic [MEM_OPT_W-1:0]  mem_opt_in,
    output logic                  do_branch,
    output logic [XLEN-1:0]       branch_dest,
    output logic                  stall_req,
    output logic                  md_busy,
    output logic                  out_valid,
    output logic [XLEN-1:0]       alu_result,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_data,
    output logic [REG_ADDR_W-1:0] wb_reg_addr,
    output logic [MEM_OPT_W-1:0]  mem_opt
);
    localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       result;
        logic [XLEN-1:0]       addr;
        logic [XLEN-1:0]       data;
        logic [REG_ADDR_W-1:0] wb;
        logic [MEM_OPT_W-1:0]  mopt;
    } exmem_t;

    logic [XLEN-1:0] op2, alu_y, ex_res;
    logic            br_cond;

    assign op2 = alu_src_imm ? imm : reg2_data;

    stage_ex_md_alu #(.XLEN(XLEN), .ALU_OPT_W(ALU_OPT_W)) u_alu (
        .opt (alu_opt),
        .a   (reg1_data),
        .b   (op2),
        .y   (alu_y)
    );

    always_comb begin
        case (branch_opt)
            2'd1:    br_cond = (alu_y == '0);
            2'd2:    br_cond = (alu_y != '0);
            2'd3:    br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign do_branch   = in_valid & br_cond;
    assign branch_dest = branch_dest_in;

    // ---------------- multiply / divide unit ----------------
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  hi, lo, md_a, md_b;
    logic [3:0]       md_op_q;
    logic             accept, is_mul, is_div, is_start, is_mt;

    assign is_mul   = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign is_div   = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign is_start = is_mul | is_div;
    assign is_mt    = (md_op == MD_MTHI) || (md_op == MD_MTLO);

    assign md_busy   = (cnt != '0);
    assign stall_req = in_valid & md_busy & (md_op != MD_NONE);
    assign accept    = in_valid & ~flush & ~stall & ~stall_req;

    logic [2*XLEN-1:0] ext_a, ext_b, prod;
    logic              mul_sgn, div_sgn, neg_a, neg_b, div_q;
    logic [XLEN-1:0]   abs_a, abs_b, quo_m, rem_m, quo, rem, res_hi, res_lo;

    always_comb begin
        mul_sgn = (md_op_q == MD_MULT);
        ext_a   = {{XLEN{mul_sgn & md_a[XLEN-1]}}, md_a};
        ext_b   = {{XLEN{mul_sgn & md_b[XLEN-1]}}, md_b};
        prod    = ext_a * ext_b;

        // Divide on magnitudes; most-negative / -1 falls out naturally because
        // the magnitude of the most-negative value is itself as an unsigned number.
        div_sgn = (md_op_q == MD_DIV);
        neg_a   = div_sgn & md_a[XLEN-1];
        neg_b   = div_sgn & md_b[XLEN-1];
        abs_a   = neg_a ? -md_a : md_a;
        abs_b   = neg_b ? -md_b : md_b;
        quo_m   = abs_a / abs_b;
        rem_m   = abs_a % abs_b;
        if (md_b == '0) begin
            quo = '1;
            rem = md_a;
        end else begin
            quo = (neg_a ^ neg_b) ? -quo_m : quo_m;
            rem = neg_a ? -rem_m : rem_m;
        end

        div_q  = (md_op_q == MD_DIV) || (md_op_q == MD_DIVU);
        res_hi = div_q ? rem : prod[2*XLEN-1:XLEN];
        res_lo = div_q ? quo : prod[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            md_a    <= '0;
            md_b    <= '0;
            md_op_q <= MD_NONE;
        end else begin
            if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            // An accepted md op can never coincide with the final count edge:
            // stall_req holds it off while the counter is nonzero.
            if (accept) begin
                if (is_start) begin
                    md_a    <= reg1_data;
                    md_b    <= reg2_data;
                    md_op_q <= md_op;
                    cnt     <= is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
                end
                if (md_op == MD_MTHI) hi <= reg1_data;
                if (md_op == MD_MTLO) lo <= reg1_data;
            end
        end
    end

    // ---------------- EX/MEM register ----------------
    always_comb begin
        case (md_op)
            MD_MFHI: ex_res = hi;
            MD_MFLO: ex_res = lo;
            default: ex_res = alu_y;
        endcase
    end

    exmem_t q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (!stall) begin
            if (!in_valid || flush || stall_req) begin
                q.valid <= 1'b0;
                q.wb    <= '0;
                q.mopt  <= '0;
            end else begin
                q.valid  <= 1'b1;
                q.result <= ex_res;
                q.addr   <= alu_y;
                q.data   <= reg2_data;
                q.wb     <= (is_start | is_mt) ? '0 : wb_reg_addr_in;
                q.mopt   <= (is_start | is_mt) ? '0 : mem_opt_in;
            end
        end
    end

    assign out_valid   = q.valid;
    assign alu_result  = q.result;
    assign mem_addr    = q.addr;
    assign mem_data    = q.data;
    assign wb_reg_addr = q.wb;
    assign mem_opt     = q.mopt;

endmodule

// Combinational alu: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU,
// 8 SLL, 9 SRL, 10 SRA, 11 LUI (upper half of b). Shifts move a by b's low bits.
module stage_ex_md_alu #(
    parameter int XLEN      = 32,
    parameter int ALU_OPT_W = 4
) (
    input  logic [ALU_OPT_W-1:0] opt,
    input  logic [XLEN-1:0]      a,
    input  logic [XLEN-1:0]      b,
    output logic [XLEN-1:0]      y
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] sh;
    assign sh = b[SH_W-1:0];

    always_comb begin
        y = '0;
        case (opt)
            ALU_OPT_W'(0):  y = a + b;
            ALU_OPT_W'(1):  y = a - b;
            ALU_OPT_W'(2):  y = a & b;
            ALU_OPT_W'(3):  y = a | b;
            ALU_OPT_W'(4):  y = a ^ b;
            ALU_OPT_W'(5):  y = ~(a | b);
            ALU_OPT_W'(6):  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_OPT_W'(7):  y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_OPT_W'(8):  y = a << sh;
            ALU_OPT_W'(9):  y = a >> sh;
            ALU_OPT_W'(10): y = $signed(a) >>> sh;
            ALU_OPT_W'(11): y = {b[XLEN/2-1:0], {(XLEN/2){1'b0}}};
            default:        y = '0;
        endcase
    end
endmodule

// File: tb/tb_stage_ex_md.sv
// Scoreboard bench for stage_ex_md: expectations queued at issue, checked as EX/MEM fills.
module tb_stage_ex_md;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_OR = 4'd3;
    localparam logic [3:0] M_MULT = 4'd1, M_MULTU = 4'd2, M_DIV = 4'd3, M_DIVU = 4'd4,
                           M_MFHI = 4'd5, M_MFLO = 4'd6, M_MTHI = 4'd7, M_MTLO = 4'd8;

    logic        clk, rst, stall, flush, in_valid, alu_src_imm;
    logic [3:0]  alu_opt, md_op;
    logic [31:0] imm, reg1_data, reg2_data, branch_dest_in;
    logic [1:0]  branch_opt;
    logic [4:0]  wb_reg_addr_in;
    logic [2:0]  mem_opt_in;
    logic        do_branch, stall_req, md_busy, out_valid;
    logic [31:0] branch_dest, alu_result, mem_addr, mem_data;
    logic [4:0]  wb_reg_addr;
    logic [2:0]  mem_opt;

    stage_ex_md dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_opt(alu_opt), .alu_src_imm(alu_src_imm), .imm(imm),
        .reg1_data(reg1_data), .reg2_data(reg2_data), .branch_opt(branch_opt),
        .branch_dest_in(branch_dest_in), .md_op(md_op), .wb_reg_addr_in(wb_reg_addr_in),
        .mem_opt_in(mem_opt_in), .do_branch(do_branch), .branch_dest(branch_dest),
        .stall_req(stall_req), .md_busy(md_busy), .out_valid(out_valid),
        .alu_result(alu_result), .mem_addr(mem_addr), .mem_data(mem_data),
        .wb_reg_addr(wb_reg_addr), .mem_opt(mem_opt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  aop;
        logic        simm;
        logic [31:0] im, r1, r2, bd;
        logic [1:0]  bop;
        logic [3:0]  mop;
        logic [4:0]  wb;
        logic [2:0]  mo;
    } ins_t;

    typedef struct {
        logic        chk_res;
        logic [31:0] res;
        logic [4:0]  wb;
        logic [2:0]  mo;
        logic        chk_mem;
        logic [31:0] ma, md;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic st_edge = 1'b1;

    function automatic ins_t alu_i(input logic [3:0] aop, input logic simm, input logic [31:0] im,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [1:0] bop, input logic [4:0] wb, input logic [2:0] mo);
        ins_t i;
        i.aop = aop; i.simm = simm; i.im = im; i.r1 = r1; i.r2 = r2;
        i.bd = 32'h0040_0000 ^ r1; i.bop = bop; i.mop = 4'd0; i.wb = wb; i.mo = mo;
        return i;
    endfunction

    function automatic ins_t md_i(input logic [3:0] mop, input logic [31:0] r1,
                                  input logic [31:0] r2, input logic [4:0] wb);
        ins_t i;
        i.aop = A_ADD; i.simm = 1'b0; i.im = 32'h0; i.r1 = r1; i.r2 = r2;
        i.bd = 32'hC0DE_0000; i.bop = 2'd0; i.mop = mop; i.wb = wb; i.mo = 3'd2;
        return i;
    endfunction

    function automatic exp_t ex(input logic cr, input logic [31:0] r, input logic [4:0] w,
                                input logic [2:0] m, input logic cm, input logic [31:0] a,
                                input logic [31:0] d);
        exp_t e;
        e.chk_res = cr; e.res = r; e.wb = w; e.mo = m; e.chk_mem = cm; e.ma = a; e.md = d;
        return e;
    endfunction

    // Capture happens on any edge where stall was low; a valid entry then must match.
    always @(posedge clk) st_edge <= stall;

    always @(negedge clk) begin
        if (rst && !st_edge && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected out_valid=1 with empty queue, res=%h wb=%0d", alu_result, wb_reg_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ((e.chk_res && alu_result !== e.res) || wb_reg_addr !== e.wb || mem_opt !== e.mo ||
                    (e.chk_mem && (mem_addr !== e.ma || mem_data !== e.md))) begin
                    errors++;
                    $display("FAIL sb_entry got res=%h wb=%0d mo=%0d ma=%h md=%h exp res=%h wb=%0d mo=%0d ma=%h md=%h",
                             alu_result, wb_reg_addr, mem_opt, mem_addr, mem_data,
                             e.res, e.wb, e.mo, e.ma, e.md);
                end
            end
        end
    end

    task automatic drive(input ins_t i);
        in_valid = 1'b1; alu_opt = i.aop; alu_src_imm = i.simm; imm = i.im;
        reg1_data = i.r1; reg2_data = i.r2; branch_opt = i.bop; branch_dest_in = i.bd;
        md_op = i.mop; wb_reg_addr_in = i.wb; mem_opt_in = i.mo;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; md_op = 4'd0; branch_opt = 2'd0;
    endtask

    // Drives at a negedge, waits out stall_req, returns at the accepting posedge.
    task automatic issue(input ins_t i, input exp_t e, input logic eb, output int sc);
        @(negedge clk);
        drive(i);
        sb.push_back(e);
        #1;
        sc = 0;
        while (stall_req && sc < 100) begin
            @(negedge clk); #1; sc++;
        end
        checks++;
        if (stall_req) begin
            errors++;
            $display("FAIL issue_timeout stall_req still 1 after %0d cycles, need 0", sc);
        end
        checks++;
        if (do_branch !== eb || branch_dest !== i.bd) begin
            errors++;
            $display("FAIL branch do_branch=%b dest=%h need %b %h", do_branch, branch_dest, eb, i.bd);
        end
        @(posedge clk);
    endtask

    task automatic md_start(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] b, output int sc);
        issue(md_i(mop, a, b, 5'd9), ex(1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 32'h0, 32'h0), 1'b0, sc);
    endtask

    task automatic mf_check(input logic [3:0] mop, input logic [31:0] v, input int exp_sc, input string nm);
        int sc;
        issue(md_i(mop, 32'h0, 32'h0, 5'd12), ex(1'b1, v, 5'd12, 3'd2, 1'b0, 32'h0, 32'h0), 1'b0, sc);
        checks++;
        if (sc !== exp_sc) begin
            errors++;
            $display("FAIL %s_stall stall cycles=%0d need %0d", nm, sc, exp_sc);
        end
    endtask

    task automatic test_reset();
        int sc;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_opt = '0; alu_src_imm = 1'b0;
        imm = '0; reg1_data = '0; reg2_data = '0; branch_opt = '0; branch_dest_in = '0;
        md_op = '0; wb_reg_addr_in = '0; mem_opt_in = '0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || alu_result !== 32'h0 || wb_reg_addr !== 5'd0 || mem_opt !== 3'd0 || md_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_init valid=%b res=%h wb=%0d mo=%0d busy=%b need all 0",
                     out_valid, alu_result, wb_reg_addr, mem_opt, md_busy);
        end
        @(negedge clk); rst = 1'b1;
        md_start(M_DIV, 32'd100, 32'd3, sc);
        idle();
        checks++;
        if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_div_busy md_busy=%b need 1", md_busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0 || out_valid !== 1'b0 || mem_opt !== 3'd0 || wb_reg_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid busy=%b valid=%b mo=%0d wb=%0d need 0", md_busy, out_valid, mem_opt, wb_reg_addr);
        end
        sb.delete();
        @(negedge clk); rst = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (md_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_after busy=%b need 0", md_busy);
        end
        mf_check(M_MFHI, 32'h0, 0, "rst_hi");
        mf_check(M_MFLO, 32'h0, 0, "rst_lo");
        idle();
    endtask

    task automatic test_alu_branch();
        int sc;
        issue(alu_i(A_ADD, 1'b0, 32'h0, 32'd3, 32'd4, 2'd0, 5'd5, 3'd0),
              ex(1'b1, 32'd7, 5'd5, 3'd0, 1'b1, 32'd7, 32'd4), 1'b0, sc);
        issue(alu_i(A_SUB, 1'b0, 32'h0, 32'd9, 32'd9, 2'd1, 5'd0, 3'd0),
              ex(1'b1, 32'd0, 5'd0, 3'd0, 1'b1, 32'd0, 32'd9), 1'b1, sc);
        issue(alu_i(A_SUB, 1'b0, 32'h0, 32'd9, 32'd9, 2'd2, 5'd0, 3'd0),
              ex(1'b1, 32'd0, 5'd0, 3'd0, 1'b1, 32'd0, 32'd9), 1'b0, sc);
        issue(alu_i(A_SUB, 1'b0, 32'h0, 32'd9, 32'd8, 2'd2, 5'd0, 3'd0),
              ex(1'b1, 32'd1, 5'd0, 3'd0, 1'b1, 32'd1, 32'd8), 1'b1, sc);
        issue(alu_i(A_OR, 1'b1, 32'h00F, 32'h0F0, 32'h5555, 2'd3, 5'd6, 3'd0),
              ex(1'b1, 32'hFF, 5'd6, 3'd0, 1'b1, 32'hFF, 32'h5555), 1'b1, sc);
        issue(alu_i(A_ADD, 1'b1, 32'd8, 32'h100, 32'hDEAD, 2'd0, 5'd10, 3'd1),
              ex(1'b1, 32'h108, 5'd10, 3'd1, 1'b1, 32'h108, 32'hDEAD), 1'b0, sc);
        @(negedge clk);
        in_valid = 1'b0; branch_opt = 2'd3; md_op = 4'd0;
        #1;
        checks++;
        if (do_branch !== 1'b0) begin
            errors++;
            $display("FAIL branch_invalid do_branch=%b need 0", do_branch);
        end
        idle();
    endtask

    task automatic test_mult();
        int sc;
        md_start(M_MULT, 32'hFFFF_FFFF, 32'd2, sc);
        mf_check(M_MFLO, 32'hFFFF_FFFE, 4, "mult_lo");
        mf_check(M_MFHI, 32'hFFFF_FFFF, 0, "mult_hi");
        md_start(M_MULTU, 32'hFFFF_FFFF, 32'd2, sc);
        mf_check(M_MFHI, 32'h0000_0001, 4, "multu_hi");
        mf_check(M_MFLO, 32'hFFFF_FFFE, 0, "multu_lo");
        idle();
    endtask

    task automatic test_div();
        int sc;
        md_start(M_DIV, 32'hFFFF_FFF9, 32'd2, sc);
        mf_check(M_MFLO, 32'hFFFF_FFFD, 32, "div_lo");
        mf_check(M_MFHI, 32'hFFFF_FFFF, 0, "div_hi");
        md_start(M_DIV, 32'd5, 32'd0, sc);
        mf_check(M_MFLO, 32'hFFFF_FFFF, 32, "div0_lo");
        mf_check(M_MFHI, 32'd5, 0, "div0_hi");
        md_start(M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, sc);
        mf_check(M_MFLO, 32'h8000_0000, 32, "divovf_lo");
        mf_check(M_MFHI, 32'h0, 0, "divovf_hi");
        md_start(M_DIVU, 32'hFFFF_FFF9, 32'd2, sc);
        mf_check(M_MFLO, 32'h7FFF_FFFC, 32, "divu_lo");
        mf_check(M_MFHI, 32'd1, 0, "divu_hi");
        idle();
    endtask

    task automatic test_mt();
        int sc;
        issue(md_i(M_MTHI, 32'h1234_5678, 32'h0, 5'd3), ex(1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 32'h0, 32'h0), 1'b0, sc);
        issue(md_i(M_MTLO, 32'hABCD_EF01, 32'h0, 5'd3), ex(1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 32'h0, 32'h0), 1'b0, sc);
        mf_check(M_MFHI, 32'h1234_5678, 0, "mthi");
        mf_check(M_MFLO, 32'hABCD_EF01, 0, "mtlo");
        idle();
    endtask

    task automatic test_stall_flush();
        int sc;
        @(negedge clk);
        stall = 1'b1;
        drive(md_i(M_MULT, 32'd3, 32'd5, 5'd9));
        sb.push_back(ex(1'b0, 32'h0, 5'd0, 3'd0, 1'b0, 32'h0, 32'h0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (md_busy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d md_busy=%b need 0", k, md_busy);
            end
        end
        stall = 1'b0;
        @(posedge clk);
        mf_check(M_MFLO, 32'd15, 4, "stall_mult");
        idle();
        md_start(M_DIV, 32'd100, 32'd7, sc);
        @(negedge clk);
        drive(alu_i(A_ADD, 1'b0, 32'h0, 32'd1, 32'd1, 2'd0, 5'd4, 3'd0));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || md_busy !== 1'b1) begin
            errors++;
            $display("FAIL flush valid=%b busy=%b need 0 1", out_valid, md_busy);
        end
        mf_check(M_MFLO, 32'd14, 30, "flush_lo");
        mf_check(M_MFHI, 32'd2, 0, "flush_hi");
        idle();
    endtask

    task automatic test_back_to_back();
        int sc;
        md_start(M_DIV, 32'd20, 32'd3, sc);
        issue(alu_i(A_ADD, 1'b1, 32'd8, 32'h200, 32'hBEEF, 2'd0, 5'd11, 3'd1),
              ex(1'b1, 32'h208, 5'd11, 3'd1, 1'b1, 32'h208, 32'hBEEF), 1'b0, sc);
        #1;
        checks++;
        if (sc !== 0 || md_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_lw stall cycles=%0d busy=%b need 0 1", sc, md_busy);
        end
        issue(alu_i(A_ADD, 1'b0, 32'h0, 32'd1, 32'd2, 2'd0, 5'd13, 3'd0),
              ex(1'b1, 32'd3, 5'd13, 3'd0, 1'b1, 32'd3, 32'd2), 1'b0, sc);
        checks++;
        if (sc !== 0) begin
            errors++;
            $display("FAIL b2b_add stall cycles=%0d need 0", sc);
        end
        md_start(M_MULT, 32'd6, 32'd7, sc);
        checks++;
        if (sc !== 30) begin
            errors++;
            $display("FAIL b2b_mult stall cycles=%0d need 30", sc);
        end
        mf_check(M_MFLO, 32'd42, 4, "b2b_lo");
        mf_check(M_MFHI, 32'd0, 0, "b2b_hi");
        idle();
    endtask

    initial begin
        test_reset();
        test_alu_branch();
        test_mult();
        test_div();
        test_mt();
        test_stall_flush();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain %0d entries left, need 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
